// File: rtl/panda_risc_v_inst_buf.sv
// Instruction buffer between fetch and decode: a first-word-fall-through FIFO
// of {msg, data} beats with flush, occupancy count and no ready pass-through.
module panda_risc_v_inst_buf #(
    parameter int  fifo_depth       = 4,
    parameter real simulation_delay = 1
) (
    input  logic                          clk,
    input  logic                          sys_resetn,
    input  logic                          flush_req,
    input  logic [127:0]                  s_if_res_data,
    input  logic [3:0]                    s_if_res_msg,
    input  logic                          s_if_res_valid,
    output logic                          s_if_res_ready,
    output logic [127:0]                  m_inst_data,
    output logic [3:0]                    m_inst_msg,
    output logic                          m_inst_valid,
    input  logic                          m_inst_ready,
    output logic [$clog2(fifo_depth):0]   inst_buf_cnt,
    output logic                          inst_buf_empty,
    output logic                          inst_buf_full
);

    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;

    typedef logic [131:0] entry_t;

    if (!(fifo_depth == 2 || fifo_depth == 4 || fifo_depth == 8 || fifo_depth == 16)
        || simulation_delay < 0.0) begin : g_bad_param
        $error("panda_risc_v_inst_buf: fifo_depth must be 2/4/8/16 and simulation_delay >= 0");
    end

    logic [ptr_w-1:0] wptr_q, wptr_d;
    logic [ptr_w-1:0] rptr_q, rptr_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    entry_t           mem_q [fifo_depth];

    logic wr_en;
    logic rd_en;

    // Status comes from the registered count only, so ready never depends on m_inst_ready.
    assign inst_buf_empty = (cnt_q == '0);
    assign inst_buf_full  = (cnt_q == cnt_w'(fifo_depth));
    assign inst_buf_cnt   = cnt_q;
    assign s_if_res_ready = ~inst_buf_full;
    assign m_inst_valid   = ~inst_buf_empty;

    // A flush swallows both handshakes: the input beat is dropped and the head is not consumed.
    assign wr_en = s_if_res_valid & s_if_res_ready & ~flush_req;
    assign rd_en = m_inst_valid & m_inst_ready & ~flush_req;

    assign {m_inst_msg, m_inst_data} = mem_q[rptr_q];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_req) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + ptr_w'(1);
            if (rd_en) rptr_d = rptr_q + ptr_w'(1);
            unique case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + cnt_w'(1);
                2'b01:   cnt_d = cnt_q - cnt_w'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: storage has no reset; an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {s_if_res_msg, s_if_res_data};
    end

endmodule

// File: tb/tb_panda_risc_v_inst_buf.sv
// Bench for panda_risc_v_inst_buf: directed scenarios plus random traffic, all
// checked by a negedge scoreboard that keeps the expected FIFO contents in a queue.
module tb_panda_risc_v_inst_buf;

    localparam int depth = 4;

    logic         clk = 1'b0;
    logic         sys_resetn = 1'b0;
    logic         flush_req = 1'b0;
    logic [127:0] s_if_res_data = '0;
    logic [3:0]   s_if_res_msg = '0;
    logic         s_if_res_valid = 1'b0;
    logic         s_if_res_ready;
    logic [127:0] m_inst_data;
    logic [3:0]   m_inst_msg;
    logic         m_inst_valid;
    logic         m_inst_ready = 1'b0;
    logic [2:0]   inst_buf_cnt;
    logic         inst_buf_empty;
    logic         inst_buf_full;

    int checks   = 0;
    int failures = 0;

    logic [131:0] exp_q[$];
    logic [31:0]  out_pcs[$];
    bit           seen_pc_100 = 1'b0;

    panda_risc_v_inst_buf #(.fifo_depth(depth), .simulation_delay(1)) dut (
        .clk            (clk),
        .sys_resetn     (sys_resetn),
        .flush_req      (flush_req),
        .s_if_res_data  (s_if_res_data),
        .s_if_res_msg   (s_if_res_msg),
        .s_if_res_valid (s_if_res_valid),
        .s_if_res_ready (s_if_res_ready),
        .m_inst_data    (m_inst_data),
        .m_inst_msg     (m_inst_msg),
        .m_inst_valid   (m_inst_valid),
        .m_inst_ready   (m_inst_ready),
        .inst_buf_cnt   (inst_buf_cnt),
        .inst_buf_empty (inst_buf_empty),
        .inst_buf_full  (inst_buf_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare the DUT against the queue model, then advance the model
    // with the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!sys_resetn) begin
            exp_q.delete();
        end else begin
            int  n;
            bit  wr;
            bit  rd;
            n = exp_q.size();
            check("sb_cnt",   132'(inst_buf_cnt),   132'(n));
            check("sb_empty", 132'(inst_buf_empty), 132'(n == 0));
            check("sb_full",  132'(inst_buf_full),  132'(n == depth));
            check("sb_ready", 132'(s_if_res_ready), 132'(n < depth));
            check("sb_valid", 132'(m_inst_valid),   132'(n > 0));
            if (n > 0) check("sb_head", {m_inst_msg, m_inst_data}, exp_q[0]);
            if (m_inst_valid && m_inst_data[127:96] == 32'h100) seen_pc_100 = 1'b1;
            if (flush_req) begin
                exp_q.delete();
            end else begin
                rd = (n > 0) && m_inst_ready;
                wr = s_if_res_valid && (n < depth);
                if (rd) begin
                    out_pcs.push_back(exp_q[0][127:96]);
                    void'(exp_q.pop_front());
                end
                if (wr) exp_q.push_back({s_if_res_msg, s_if_res_data});
            end
        end
    end

    // Drive one cycle of inputs and return 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [127:0] d, input logic [3:0] m,
                        input logic r, input logic f);
        s_if_res_valid = v;
        s_if_res_data  = d;
        s_if_res_msg   = m;
        m_inst_ready   = r;
        flush_req      = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat(input logic [31:0] pc, input logic [31:0] inst);
        return {pc, $urandom(), $urandom(), inst};
    endfunction

    initial begin
        logic [127:0] d0;

        // Reset values while sys_resetn is held low.
        #3;
        check("rst_cnt",   132'(inst_buf_cnt),   132'(0));
        check("rst_empty", 132'(inst_buf_empty), 132'(1));
        check("rst_full",  132'(inst_buf_full),  132'(0));
        check("rst_valid", 132'(m_inst_valid),   132'(0));
        check("rst_ready", 132'(s_if_res_ready), 132'(1));
        @(posedge clk);
        #1;
        sys_resetn = 1'b1;
        step(0, '0, '0, 0, 0);

        // Single beat with the decode stage stalled.
        d0 = {32'h0000_1000, 64'h0, 32'h0000_0013};
        step(1, d0, 4'b0000, 0, 0);
        check("single_valid", 132'(m_inst_valid), 132'(1));
        check("single_data",  {m_inst_msg, m_inst_data}, {4'b0000, d0});
        check("single_cnt",   132'(inst_buf_cnt), 132'(1));
        step(0, '0, '0, 1, 0);
        check("single_drain", 132'(inst_buf_cnt), 132'(0));

        // Fill, refuse a fifth beat, then read while full.
        for (int i = 0; i < depth; i++) step(1, beat(32'h200 + 32'(4 * i), 32'h13), 4'(i), 0, 0);
        check("fill_full",  132'(inst_buf_full),  132'(1));
        check("fill_ready", 132'(s_if_res_ready), 132'(0));
        check("fill_cnt",   132'(inst_buf_cnt),   132'(4));
        step(1, beat(32'h300, 32'h13), 4'hf, 0, 0);
        check("fifth_cnt",  132'(inst_buf_cnt),   132'(4));
        step(1, beat(32'h304, 32'h13), 4'he, 1, 0);
        check("full_rd_cnt", 132'(inst_buf_cnt),  132'(3));
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
        check("fill_drained", 132'(inst_buf_empty), 132'(1));

        // Streaming across several pointer wraps.
        out_pcs.delete();
        for (int i = 0; i < 10; i++) begin
            step(1, beat(32'(4 * i), 32'h13), 4'(i), 1, 0);
            check("stream_cnt", 132'(inst_buf_cnt), 132'(1));
        end
        step(0, '0, '0, 1, 0);
        check("stream_count", 132'(out_pcs.size()), 132'(10));
        for (int i = 0; i < 10 && i < out_pcs.size(); i++)
            check("stream_order", 132'(out_pcs[i]), 132'(4 * i));

        // Flush with a concurrent input and output handshake.
        for (int i = 0; i < 3; i++) step(1, beat(32'h400 + 32'(4 * i), 32'h13), 4'h1, 0, 0);
        step(1, beat(32'h100, 32'h13), 4'h8, 1, 1);
        check("flush_cnt",   132'(inst_buf_cnt), 132'(0));
        check("flush_valid", 132'(m_inst_valid), 132'(0));
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);
        check("flush_stays_empty", 132'(inst_buf_cnt), 132'(0));

        // Random traffic; odd PCs keep 32'h100 unique to the flush test.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), beat($urandom() | 32'h1, $urandom()),
                 4'($urandom()), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

        // Asynchronous reset between clock edges with two entries held.
        step(0, '0, '0, 1, 1);
        step(1, beat(32'h501, 32'h13), 4'h2, 0, 0);
        step(1, beat(32'h505, 32'h13), 4'h3, 0, 0);
        check("pre_arst_cnt", 132'(inst_buf_cnt), 132'(2));
        s_if_res_valid = 1'b0;
        #2;
        sys_resetn = 1'b0;
        #1;
        check("arst_valid", 132'(m_inst_valid),   132'(0));
        check("arst_cnt",   132'(inst_buf_cnt),   132'(0));
        check("arst_empty", 132'(inst_buf_empty), 132'(1));
        check("arst_ready", 132'(s_if_res_ready), 132'(1));
        @(posedge clk);
        #1;
        sys_resetn = 1'b1;
        step(0, '0, '0, 1, 0);
        check("post_arst_cnt", 132'(inst_buf_cnt), 132'(0));
        for (int i = 0; i < 100; i++)
            step(1'($urandom_range(0, 1)), beat($urandom() | 32'h1, $urandom()),
                 4'($urandom()), 1'($urandom_range(0, 1)), 1'b0);

        step(0, '0, '0, 0, 0);
        check("pc_100_never_out", 132'(seen_pc_100), 132'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panda_risc_v_inst_buf.md
PANDA_RISC_V_INST_BUF -- requirements
Module: panda_risc_v_inst_buf

Interface
REQ-001 SHALL have parameter fifo_depth, default 4, entry count; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter simulation_delay, default 1, real-valued register update delay used in simulation only.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_req  input  1  discard all buffered instructions.
REQ-006 SHALL have port s_if_res_data  input  128  fetch result: {PC[31:0], pre-decode info[63:0], instruction[31:0]}.
REQ-007 SHALL have port s_if_res_msg  input  4  {predicted jump, illegal inst, imem error code[1:0]}.
REQ-008 SHALL have port s_if_res_valid  input  1  upstream beat valid.
REQ-009 SHALL have port s_if_res_ready  output  1  buffer can accept a beat.
REQ-010 SHALL have port m_inst_data  output  128  head entry data, same packing as s_if_res_data.
REQ-011 SHALL have port m_inst_msg  output  4  head entry message, same packing as s_if_res_msg.
REQ-012 SHALL have port m_inst_valid  output  1  head entry valid.
REQ-013 SHALL have port m_inst_ready  input  1  downstream decode stage accepts the head entry.
REQ-014 SHALL have port inst_buf_cnt  output  clog2(fifo_depth)+1  current occupancy.
REQ-015 SHALL have port inst_buf_empty  output  1  occupancy == 0.
REQ-016 SHALL have port inst_buf_full  output  1  occupancy == fifo_depth.

Function
REQ-017 SHALL implement a first-word-fall-through FIFO of fifo_depth entries of 132 bits each ({msg, data}).
REQ-018 SHALL accept a write when s_if_res_valid & s_if_res_ready; s_if_res_ready SHALL equal ~inst_buf_full, with no combinational path from m_inst_ready.
REQ-019 SHALL perform a read when m_inst_valid & m_inst_ready; m_inst_valid SHALL equal ~inst_buf_empty.
REQ-020 SHALL drive m_inst_data/m_inst_msg from the entry at the read pointer; the value is don't-care when empty.
REQ-021 SHALL present a beat written in cycle N on m_inst_valid in cycle N+1 (latency 1), with no bypass of an empty buffer.
REQ-022 SHALL keep write/read pointers of clog2(fifo_depth) bits that wrap from fifo_depth-1 to 0 modulo fifo_depth.
REQ-023 SHALL update occupancy as follows: write only +1; read only -1; simultaneous write and read unchanged; neither unchanged.
REQ-024 SHALL, on a simultaneous write and read at occupancy 1, output the newly written entry in the next cycle.
REQ-025 SHALL give flush_req priority over everything: in a flush cycle, set both pointers and inst_buf_cnt to 0 on the next edge.
REQ-026 SHALL, in a flush cycle, discard the input beat even if a handshake occurs, and apply no read pointer update from any output handshake.
REQ-027 SHALL keep s_if_res_ready = ~inst_buf_full during flush; the handshake completes and the data is dropped.
REQ-028 SHALL assert inst_buf_empty/inst_buf_full combinationally from the registered occupancy only.
REQ-029 SHALL never overwrite an unread entry and never underflow; a read when empty is impossible by REQ-019.

Reset
REQ-030 SHALL, while sys_resetn is low, asynchronously clear pointers and occupancy: inst_buf_cnt=0, inst_buf_empty=1, inst_buf_full=0, m_inst_valid=0, s_if_res_ready=1.
REQ-031 SHALL not reset entry storage; its contents are unobservable until written.
REQ-032 SHALL, on reset asserted mid-operation, lose all buffered entries and behave as freshly reset after release.

Verification
REQ-033 SHALL cover the single-beat test: depth 4; write data=128'h...0000_1000_..._0000_0013, msg=4'b0000 with m_inst_ready=0 -> m_inst_valid=1 next cycle with identical data/msg; inst_buf_cnt=1.
REQ-034 SHALL cover the fill test: depth 4; 4 writes with m_inst_ready=0 -> inst_buf_full=1, s_if_res_ready=0, inst_buf_cnt=4; a 5th presented beat is not accepted.
REQ-035 SHALL cover streaming and wrap: depth 4; 10 consecutive beats with PC=0,4,...,36 and m_inst_ready=1 -> output order PC 0..36 with no loss; inst_buf_cnt stays 1 in steady state.
REQ-036 SHALL cover the flush test: 3 entries held, flush_req=1 for one cycle with s_if_res_valid=1 (PC=32'h100) and m_inst_ready=1 -> next cycle inst_buf_cnt=0, m_inst_valid=0; PC 32'h100 never appears.
REQ-037 SHALL cover full with simultaneous read: full buffer, m_inst_ready=1, s_if_res_valid=1 -> only the read occurs (ready=0), inst_buf_cnt=3.
REQ-038 SHALL cover asynchronous reset: sys_resetn driven low between clock edges with 2 entries held -> m_inst_valid=0 and inst_buf_cnt=0 immediately, without waiting for a clk edge.
